inv_clarke_module: RTL

Inverse Clarke transformation core: converts a stationary-frame vector (alpha, beta) back into three balanced phase quantities a, b, c. Results are saturated to DATA_WIDTH. It sits at the output end of the control path, after the PI/inverse-Park stage and before the PWM/SVM generator, mirroring the forward Clarke core on the measurement side. A small FSM shares one multiplier, with valid/ready handshakes on both sides.

---
 rtl/inv_clarke_module_pkg.sv | 33 +++
 rtl/inv_clarke_module_if.sv | 33 +++
 rtl/sat_module.sv | 32 +++
 rtl/inv_clarke_module.sv | 123 ++++++++++++
 4 files changed

// File: rtl/inv_clarke_module_pkg.sv
// ----------------------------------------------------------------------------
// clarke_pkg: shared FSM encoding, constants and saturation bounds.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package clarke_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SUM  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // sqrt(3)/2 scaled to full scale of a Q(width-1) word, truncated toward zero
  function automatic int sqrt3_div2(input int width);
    longint full_scale;
    full_scale = (longint'(1) << (width - 1)) - 1;
    return int'((full_scale * 64'sd866025404) / 64'sd1000000000);
  endfunction

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/inv_clarke_module_if.sv
// ----------------------------------------------------------------------------
// inv_clarke_module_if: input/output valid-ready handshakes and data buses.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface inv_clarke_module_if #(
  parameter int DATA_WIDTH = 10
);

  logic                         in_valid_i;
  logic                         in_ready_o;
  logic signed [DATA_WIDTH-1:0] al_i;
  logic signed [DATA_WIDTH-1:0] be_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic signed [DATA_WIDTH-1:0] a_o;
  logic signed [DATA_WIDTH-1:0] b_o;
  logic signed [DATA_WIDTH-1:0] c_o;

  modport master (
    output in_valid_i, al_i, be_i, out_ready_i,
    input  in_ready_o, out_valid_o, a_o, b_o, c_o
  );

  modport slave (
    input  in_valid_i, al_i, be_i, out_ready_i,
    output in_ready_o, out_valid_o, a_o, b_o, c_o
  );

endinterface

`default_nettype wire

// File: rtl/sat_module.sv
// ----------------------------------------------------------------------------
// sat_module: combinational signed saturation from IN_W to OUT_W bits.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_module
  import clarke_pkg::*;
#(
  parameter int IN_W  = 11,
  parameter int OUT_W = 10
) (
  input  logic signed [IN_W-1:0]  d_i,
  output logic signed [OUT_W-1:0] q_o
);

  localparam logic signed [IN_W-1:0] C_MAX = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] C_MIN = IN_W'(sat_min(OUT_W));

  always_comb begin
    if (d_i > C_MAX) begin
      q_o = C_MAX[OUT_W-1:0];
    end else if (d_i < C_MIN) begin
      q_o = C_MIN[OUT_W-1:0];
    end else begin
      q_o = d_i[OUT_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/inv_clarke_module.sv
// ----------------------------------------------------------------------------
// inv_clarke_module: inverse Clarke transform (alpha,beta -> a,b,c) with a
// four-state FSM sharing one multiplier. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inv_clarke_module
  import clarke_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  inv_clarke_module_if.slave bus
);

  localparam int PW = 2 * DATA_WIDTH - 1;
  localparam int SW = DATA_WIDTH + 1;
  localparam logic signed [PW-1:0] C_SQRT3 = PW'(sqrt3_div2(DATA_WIDTH));

  state_e state_q, state_d;

  logic signed [DATA_WIDTH-1:0] al_q, al_d;
  logic signed [DATA_WIDTH-1:0] be_q, be_d;
  logic signed [DATA_WIDTH-1:0] bs_q, bs_d;
  logic signed [DATA_WIDTH-1:0] a_q, a_d;
  logic signed [DATA_WIDTH-1:0] b_q, b_d;
  logic signed [DATA_WIDTH-1:0] c_q, c_d;

  logic signed [PW-1:0]         w_prod;
  logic signed [DATA_WIDTH-1:0] w_bs;
  logic                         w_unused_lsbs;
  logic signed [SW-1:0]         w_half;
  logic signed [SW-1:0]         w_bs_ext;
  logic signed [SW-1:0]         w_b_sum;
  logic signed [SW-1:0]         w_c_sum;
  logic signed [DATA_WIDTH-1:0] w_b_sat;
  logic signed [DATA_WIDTH-1:0] w_c_sat;

  // Taking the upper slice of the product is the floor shift by DATA_WIDTH-1
  assign w_prod        = $signed({{(PW - DATA_WIDTH){be_q[DATA_WIDTH-1]}}, be_q}) * C_SQRT3;
  assign w_bs          = w_prod[PW-1:DATA_WIDTH-1];
  assign w_unused_lsbs = ^w_prod[DATA_WIDTH-2:0];

  assign w_half   = {{2{al_q[DATA_WIDTH-1]}}, al_q[DATA_WIDTH-1:1]};
  assign w_bs_ext = {bs_q[DATA_WIDTH-1], bs_q};
  assign w_b_sum  = w_bs_ext - w_half;
  assign w_c_sum  = -w_half - w_bs_ext;

  sat_module #(.IN_W(SW), .OUT_W(DATA_WIDTH)) u_sat_b (
    .d_i (w_b_sum),
    .q_o (w_b_sat)
  );

  sat_module #(.IN_W(SW), .OUT_W(DATA_WIDTH)) u_sat_c (
    .d_i (w_c_sum),
    .q_o (w_c_sat)
  );

  always_comb begin
    state_d = state_q;
    al_d    = al_q;
    be_d    = be_q;
    bs_d    = bs_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          al_d    = bus.al_i;
          be_d    = bus.be_i;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        bs_d    = w_bs;
        state_d = ST_SUM;
      end
      ST_SUM: begin
        a_d     = al_q;
        b_d     = w_b_sat;
        c_d     = w_c_sat;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      al_q    <= '0;
      be_q    <= '0;
      bs_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      al_q    <= al_d;
      be_q    <= be_d;
      bs_q    <= bs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE);
  assign bus.out_valid_o = (state_q == ST_OUT);
  assign bus.a_o         = a_q;
  assign bus.b_o         = b_q;
  assign bus.c_o         = c_q;

endmodule

`default_nettype wire
